branch_resolve_unit: RTL

Parametrised successor to the combinational branch comparator. Registered branch-resolution stage in the EX pipeline slot: evaluates the branch condition, compares it against the front-end prediction, and issues a one-cycle redirect/flush. Squashes wrong-path branches for a programmable kill window. Keeps saturating branch and mispredict statistics.

---
 rtl/branch_pkg.sv | 14 +
 rtl/branch_cond.sv | 38 +++
 rtl/branch_resolve_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared constants for the branch resolution stage: condition-code encodings
// (ALUFunct[4:1]) and the condition-code width.
package branch_pkg;

  localparam int FUNCT_W = 4;

  localparam logic [FUNCT_W-1:0] F_BNE  = 4'b1000;
  localparam logic [FUNCT_W-1:0] F_BEQ  = 4'b1001;
  localparam logic [FUNCT_W-1:0] F_BLTZ = 4'b1100;
  localparam logic [FUNCT_W-1:0] F_BGEZ = 4'b1101;
  localparam logic [FUNCT_W-1:0] F_BLEZ = 4'b1110;
  localparam logic [FUNCT_W-1:0] F_BGTZ = 4'b1111;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: signed two's-complement compare of
// rs (and rt for beq/bne) selected by the condition code.
module branch_cond
  import branch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               taken_o,
  output logic               illegal_o
);

  logic a_neg_s;
  logic a_zero_s;
  logic a_eq_b_s;

  assign a_neg_s  = a_i[WIDTH-1];
  assign a_zero_s = (a_i == '0);
  assign a_eq_b_s = (a_i == b_i);

  // Undefined codes never take the branch.
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct_i)
      F_BEQ:   taken_o = a_eq_b_s;
      F_BNE:   taken_o = ~a_eq_b_s;
      F_BLEZ:  taken_o = a_neg_s | a_zero_s;
      F_BGTZ:  taken_o = ~a_neg_s & ~a_zero_s;
      F_BLTZ:  taken_o = a_neg_s;
      F_BGEZ:  taken_o = ~a_neg_s;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered EX-stage branch resolution: compares the actual outcome with the
// front-end prediction, pulses flush/redirect and squashes the wrong-path window.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PC_WIDTH    = 32,
  parameter int KILL_CYCLES = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 in_valid,
  input  logic [FUNCT_W-1:0]   in_funct,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_pred_taken,
  input  logic [PC_WIDTH-1:0]  in_target,
  input  logic [PC_WIDTH-1:0]  in_fallthru,
  output logic                 in_ready,
  output logic                 res_valid,
  output logic                 res_taken,
  output logic                 res_illegal,
  output logic                 flush,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam logic [3:0]           KILL_INIT = 4'(KILL_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic                 cond_taken_s;
  logic                 cond_illegal_s;
  logic                 accept_s;
  logic                 mispredict_s;

  logic                 res_valid_q,   res_valid_d;
  logic                 res_taken_q,   res_taken_d;
  logic                 res_illegal_q, res_illegal_d;
  logic                 flush_q,       flush_d;
  logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
  logic [3:0]           kill_q,        kill_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q,  branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  branch_cond #(
    .WIDTH (WIDTH)
  ) u_cond (
    .funct_i   (in_funct),
    .a_i       (in_a),
    .b_i       (in_b),
    .taken_o   (cond_taken_s),
    .illegal_o (cond_illegal_s)
  );

  assign in_ready = ~stall;
  assign accept_s = in_valid & ~stall;

  // Resolution, kill window and statistics next state; stall holds everything but clr_stats.
  always_comb begin
    res_valid_d   = res_valid_q;
    res_taken_d   = res_taken_q;
    res_illegal_d = res_illegal_q;
    flush_d       = flush_q;
    redirect_pc_d = redirect_pc_q;
    kill_d        = kill_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    mispredict_s  = cond_taken_s ^ in_pred_taken;

    if (!stall) begin
      res_valid_d = 1'b0;
      flush_d     = 1'b0;
      if (accept_s) begin
        if (kill_q != 4'd0) begin
          kill_d = kill_q - 4'd1;
        end else begin
          res_valid_d   = 1'b1;
          res_taken_d   = cond_taken_s;
          res_illegal_d = cond_illegal_s;
          flush_d       = mispredict_s;
          redirect_pc_d = cond_taken_s ? in_target : in_fallthru;
          kill_d        = mispredict_s ? KILL_INIT : 4'd0;
        end
      end else begin
        kill_d = kill_q;
      end
      if (res_valid_d && (branch_cnt_q != CNT_MAX)) begin
        branch_cnt_d = branch_cnt_q + CNT_ONE;
      end else begin
        branch_cnt_d = branch_cnt_q;
      end
      if (flush_d && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_ONE;
      end else begin
        mispred_cnt_d = mispred_cnt_q;
      end
    end else begin
      kill_d = kill_q;
    end

    if (clr_stats) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else begin
      mispred_cnt_d = mispred_cnt_d;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      kill_q        <= 4'd0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      res_valid_q   <= res_valid_d;
      res_taken_q   <= res_taken_d;
      res_illegal_q <= res_illegal_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      kill_q        <= kill_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign res_illegal = res_illegal_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
